// File: rtl/taito_savestate_pkg.sv
// -----------------------------------------------------------------------------
// taito_savestate_pkg
// Shared definitions for the savestate sequencer: operation direction,
// error codes, sequencer state encoding and the default DDR slot layout.
// The layout constants live here so that streamer tooling and HPS software
// compute the same slot windows as the RTL.
// -----------------------------------------------------------------------------
package taito_savestate_pkg;

    // Direction of a savestate operation.
    typedef enum logic {
        OP_SAVE = 1'b0,   // core state -> DDR
        OP_LOAD = 1'b1    // DDR -> core state
    } op_t;

    // Error codes reported on err_code.
    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_PAUSE_TO = 2'd1;
    localparam logic [1:0] ERR_START_TO = 2'd2;

    // Sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_PAUSE_WAIT = 3'd1,
        ST_SETTLE     = 3'd2,
        ST_START      = 3'd3,
        ST_RUN        = 3'd4,
        ST_RESUME     = 3'd5
    } state_t;

    // Default DDR layout: slot n lives at BASE + n * SLOT_SIZE.
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h3000_0000;
    localparam logic [31:0] DEFAULT_SLOT_SIZE = 32'h0040_0000;

endpackage

// File: rtl/savestate_sequencer.sv
// -----------------------------------------------------------------------------
// savestate_sequencer
// Runs one savestate save or load: pauses the game core, waits for it to
// settle, starts the chunked memory streamer in the requested direction over
// the slot's DDR window, waits for the streamer to finish and resumes the core.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   save_req, load_req   single-cycle requests (save wins if both high)
//   slot                 slot index, sampled with the request
//   core_pause_req       level, asks the core to halt
//   core_paused          core halted acknowledge
//   stream_start_addr    DDR byte address of the slot window
//   stream_length        window length in bytes
//   stream_write_start   one-cycle start pulse for a save (chunks -> DDR)
//   stream_read_start    one-cycle start pulse for a load (DDR -> chunks)
//   stream_busy          streamer busy
//   busy                 high whenever not idle
//   done, error          one-cycle completion / abort pulses
//   err_code             0 none, 1 pause timeout, 2 start timeout
//   last_slot            slot of the last accepted request
//   dropped              one-cycle pulse for a request that arrived while busy
// -----------------------------------------------------------------------------
module savestate_sequencer
    import taito_savestate_pkg::*;
#(
    parameter int unsigned SLOT_BITS     = 2,
    parameter logic [31:0] BASE_ADDR     = DEFAULT_BASE_ADDR,
    parameter logic [31:0] SLOT_SIZE     = DEFAULT_SLOT_SIZE,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned PAUSE_TIMEOUT = 1048576,
    parameter int unsigned START_TIMEOUT = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 save_req,
    input  logic                 load_req,
    input  logic [SLOT_BITS-1:0] slot,
    output logic                 core_pause_req,
    input  logic                 core_paused,
    output logic [31:0]          stream_start_addr,
    output logic [31:0]          stream_length,
    output logic                 stream_write_start,
    output logic                 stream_read_start,
    input  logic                 stream_busy,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [1:0]           err_code,
    output logic [SLOT_BITS-1:0] last_slot,
    output logic                 dropped
);

    // One counter is shared by PAUSE_WAIT, SETTLE and RUN; the pause timeout
    // is the largest bound, so it sets the width.
    localparam int unsigned      CNT_W       = $clog2(PAUSE_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] PAUSE_LAST  = CNT_W'(PAUSE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] START_LAST  = CNT_W'(START_TIMEOUT - 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
    op_t                  op_q, op_d;
    logic                 seen_q, seen_d;      // stream_busy observed high in RUN
    logic                 pause_q, pause_d;
    logic [31:0]          addr_q, addr_d;
    logic [31:0]          len_q, len_d;
    logic [1:0]           err_code_q, err_code_d;
    logic [SLOT_BITS-1:0] last_slot_q, last_slot_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;
    logic                 dropped_q, dropped_d;

    logic any_req;
    assign any_req = save_req | load_req;

    // Saturating increment so a stalled state can never wrap the counter.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    // NOTE: every variable written here gets its default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        seen_d      = seen_q;
        pause_d     = pause_q;
        addr_d      = addr_q;
        len_d       = len_q;
        err_code_d  = err_code_q;
        last_slot_d = last_slot_q;
        done_d      = 1'b0;
        error_d     = 1'b0;
        dropped_d   = (state_q != ST_IDLE) && any_req;

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    op_d        = save_req ? OP_SAVE : OP_LOAD;
                    last_slot_d = slot;
                    err_code_d  = ERR_NONE;
                    addr_d      = BASE_ADDR + 32'(slot) * SLOT_SIZE;
                    len_d       = SLOT_SIZE;
                    pause_d     = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_PAUSE_WAIT;
                end
            end
            ST_PAUSE_WAIT: begin
                // An acknowledge in the final counted cycle still wins.
                if (core_paused) begin
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end else if (cnt_q == PAUSE_LAST) begin
                    pause_d    = 1'b0;
                    err_code_d = ERR_PAUSE_TO;
                    error_d    = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_START;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_START: begin
                // The start pulse is decoded from this one-cycle state.
                cnt_d   = '0;
                seen_d  = 1'b0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (stream_busy) begin
                    seen_d = 1'b1;
                end else if (seen_q) begin
                    state_d = ST_RESUME;
                end else if (cnt_q == START_LAST) begin
                    err_code_d = ERR_START_TO;
                    error_d    = 1'b1;
                    state_d    = ST_RESUME;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_RESUME: begin
                pause_d = 1'b0;
                done_d  = (err_code_q == ERR_NONE);
                state_d = ST_IDLE;
            end
            default: begin
                pause_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            op_q        <= OP_SAVE;
            seen_q      <= 1'b0;
            pause_q     <= 1'b0;
            addr_q      <= BASE_ADDR;
            len_q       <= SLOT_SIZE;
            err_code_q  <= ERR_NONE;
            last_slot_q <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            dropped_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            seen_q      <= seen_d;
            pause_q     <= pause_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            err_code_q  <= err_code_d;
            last_slot_q <= last_slot_d;
            done_q      <= done_d;
            error_q     <= error_d;
            dropped_q   <= dropped_d;
        end
    end

    assign core_pause_req     = pause_q;
    assign stream_start_addr  = addr_q;
    assign stream_length      = len_q;
    assign stream_write_start = (state_q == ST_START) && (op_q == OP_SAVE);
    assign stream_read_start  = (state_q == ST_START) && (op_q == OP_LOAD);
    assign busy               = (state_q != ST_IDLE);
    assign done               = done_q;
    assign error              = error_q;
    assign err_code           = err_code_q;
    assign last_slot          = last_slot_q;
    assign dropped            = dropped_q;

endmodule

// File: tb/tb_savestate_sequencer.sv
// -----------------------------------------------------------------------------
// tb_savestate_sequencer
// Directed and randomized operations against savestate_sequencer. The bench
// plays the core (pause acknowledge) and the streamer (busy after a start
// pulse) and predicts every operation's outcome and timing from the
// sequencing rules with plain cycle arithmetic.
// Cycle t of an operation is the cycle after the t-th clock edge following
// the edge that accepts the request; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_savestate_sequencer;
    import taito_savestate_pkg::*;

    localparam int SB     = 2;
    localparam int SC     = 16;   // settle cycles
    localparam int PT     = 32;   // pause timeout
    localparam int ST     = 8;    // start timeout
    localparam int BUDGET = 400;

    logic          clk = 1'b0;
    logic          reset;
    logic          save_req, load_req;
    logic [SB-1:0] slot;
    logic          core_pause_req, core_paused;
    logic [31:0]   stream_start_addr, stream_length;
    logic          stream_write_start, stream_read_start, stream_busy;
    logic          busy, done, error, dropped;
    logic [1:0]    err_code;
    logic [SB-1:0] last_slot;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    savestate_sequencer #(
        .SLOT_BITS    (SB),
        .BASE_ADDR    (DEFAULT_BASE_ADDR),
        .SLOT_SIZE    (DEFAULT_SLOT_SIZE),
        .SETTLE_CYCLES(SC),
        .PAUSE_TIMEOUT(PT),
        .START_TIMEOUT(ST)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .save_req          (save_req),
        .load_req          (load_req),
        .slot              (slot),
        .core_pause_req    (core_pause_req),
        .core_paused       (core_paused),
        .stream_start_addr (stream_start_addr),
        .stream_length     (stream_length),
        .stream_write_start(stream_write_start),
        .stream_read_start (stream_read_start),
        .stream_busy       (stream_busy),
        .busy              (busy),
        .done              (done),
        .error             (error),
        .err_code          (err_code),
        .last_slot         (last_slot),
        .dropped           (dropped)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected outcome of one operation.
    // kind: 0 done, 1 pause timeout, 2 start timeout.
    // start: cycle of the start pulse; ev: cycle of done/error pulse;
    // finish: first cycle with busy low again.
    typedef struct {
        int          kind;
        int          start;
        int          ev;
        int          finish;
        logic [1:0]  code;
        logic [31:0] addr;
    } exp_t;

    // p: cycle core_paused first rises (-1 never); b: cycles after the start
    // pulse's following cycle before streamer busy rises (-1 never);
    // l: cycles streamer stays busy.
    function automatic exp_t predict(input int s, input int p, input int b, input int l);
        exp_t e;
        logic [31:0] slot_w;
        slot_w = 32'(s);
        e.addr = DEFAULT_BASE_ADDR + slot_w * DEFAULT_SLOT_SIZE;
        if (p < 0 || p >= PT) begin
            // Pause wait lasts PT cycles (0..PT-1); abort shows on cycle PT.
            e.kind = 1; e.start = -1; e.ev = PT; e.finish = PT; e.code = ERR_PAUSE_TO;
        end else begin
            // Ack seen in cycle p, settle occupies p+1..p+SC, pulse next.
            e.start = p + 1 + SC;
            if (b >= 0 && b < ST) begin
                // busy high start+1+b .. start+b+l, first low cycle start+1+b+l,
                // one resume cycle, then done.
                e.kind = 0; e.ev = e.start + 3 + b + l; e.finish = e.ev; e.code = ERR_NONE;
            end else begin
                // ST cycles of waiting for busy, error enters with resume.
                e.kind = 2; e.ev = e.start + 1 + ST; e.finish = e.start + 2 + ST; e.code = ERR_START_TO;
            end
        end
        return e;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, ".pause_req"}, core_pause_req, 0);
        check({tag, ".write_start"}, stream_write_start, 0);
        check({tag, ".read_start"}, stream_read_start, 0);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".done"}, done, 0);
        check({tag, ".error"}, error, 0);
        check({tag, ".err_code"}, err_code, 0);
        check({tag, ".last_slot"}, last_slot, 0);
        check({tag, ".dropped"}, dropped, 0);
        check({tag, ".addr"}, stream_start_addr, DEFAULT_BASE_ADDR);
        check({tag, ".length"}, stream_length, DEFAULT_SLOT_SIZE);
    endtask

    // drop: -1 none, -2 random cycle inside the operation, else that cycle.
    task automatic run_op(input string name, input bit do_save, input bit do_load,
                          input int s, input int p, input int b, input int l, input int drop);
        exp_t        e;
        bit          save_op;
        int          drop_at;
        int          n_ws, n_rs, n_done, n_err, n_drop;
        int          t_ws, t_rs, t_done, t_err, t_drop, t_end, st_ref;
        logic [31:0] a_start, l_start;
        bit          pause_gap, quiet;

        save_op = do_save;
        e = predict(s, p, b, l);
        drop_at = (drop == -2) ? int'($urandom_range(e.finish - 1, 1)) : drop;
        n_ws = 0; n_rs = 0; n_done = 0; n_err = 0; n_drop = 0;
        t_ws = -1; t_rs = -1; t_done = -1; t_err = -1; t_drop = -1; t_end = -1;
        a_start = '0; l_start = '0; pause_gap = 1'b0;

        save_req = do_save; load_req = do_load; slot = SB'(s);
        @(posedge clk); #1;
        save_req = 1'b0; load_req = 1'b0; slot = SB'($urandom);

        for (int t = 0; t < BUDGET; t++) begin
            st_ref = (t_ws >= 0) ? t_ws : t_rs;
            // After the acknowledge, the core may wobble freely.
            if (p >= 0 && t == p)     core_paused = 1'b1;
            else if (p >= 0 && t > p) core_paused = 1'($urandom_range(1, 0));
            else                      core_paused = 1'b0;
            stream_busy = (st_ref >= 0 && b >= 0 && t >= st_ref + 1 + b && t < st_ref + 1 + b + l);
            if (t == drop_at) begin
                if ($urandom_range(1, 0) == 1) save_req = 1'b1;
                else                           load_req = 1'b1;
            end else begin
                save_req = 1'b0; load_req = 1'b0;
            end
            @(negedge clk);
            if (stream_write_start) begin
                n_ws++; t_ws = t; a_start = stream_start_addr; l_start = stream_length;
            end
            if (stream_read_start) begin
                n_rs++; t_rs = t; a_start = stream_start_addr; l_start = stream_length;
            end
            if (done)    begin n_done++; t_done = t; end
            if (error)   begin n_err++;  t_err  = t; end
            if (dropped) begin n_drop++; t_drop = t; end
            if (!busy) begin
                t_end = t;
                break;
            end
            if (!core_pause_req) pause_gap = 1'b1;
            @(posedge clk); #1;
        end

        check({name, ".finish"}, t_end, e.finish);
        check({name, ".pause_low"}, core_pause_req, 0);
        check({name, ".pause_held"}, pause_gap, 0);
        check({name, ".n_write"}, n_ws, (e.kind != 1 && save_op) ? 1 : 0);
        check({name, ".n_read"}, n_rs, (e.kind != 1 && !save_op) ? 1 : 0);
        if (e.kind != 1) begin
            check({name, ".t_start"}, save_op ? t_ws : t_rs, e.start);
            check({name, ".addr_at_start"}, a_start, e.addr);
            check({name, ".len_at_start"}, l_start, DEFAULT_SLOT_SIZE);
        end
        check({name, ".n_done"}, n_done, (e.kind == 0) ? 1 : 0);
        check({name, ".n_error"}, n_err, (e.kind != 0) ? 1 : 0);
        if (e.kind == 0) check({name, ".t_done"}, t_done, e.ev);
        else             check({name, ".t_error"}, t_err, e.ev);
        check({name, ".err_code"}, err_code, e.code);
        check({name, ".last_slot"}, last_slot, s);
        check({name, ".addr_end"}, stream_start_addr, e.addr);
        check({name, ".len_end"}, stream_length, DEFAULT_SLOT_SIZE);
        check({name, ".n_dropped"}, n_drop, (drop_at >= 0) ? 1 : 0);
        if (drop_at >= 0) check({name, ".t_dropped"}, t_drop, drop_at + 1);

        // Quiet period: nothing may start on its own (e.g. from a dropped request).
        @(posedge clk); #1;
        core_paused = 1'b0; stream_busy = 1'b0; save_req = 1'b0; load_req = 1'b0;
        quiet = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (busy || core_pause_req || stream_write_start || stream_read_start) quiet = 1'b0;
        end
        check({name, ".quiet_after"}, quiet, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        bit got_start;
        bit quiet;
        bit sv;
        bit ld;

        reset = 1'b1; save_req = 1'b0; load_req = 1'b0; slot = '0;
        core_paused = 1'b0; stream_busy = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed scenarios.
        run_op("save_slot2", 1, 0, 2, 3, 0, 100, -1);
        run_op("load_slot0", 0, 1, 0, 1, 1, 5, -1);
        run_op("both_slot1_drop", 1, 1, 1, 0, 0, 20, 25);
        run_op("pause_timeout", 1, 0, 3, -1, 0, 1, -1);
        run_op("start_timeout", 0, 1, 2, 2, -1, 1, -1);
        run_op("pause_last_cycle", 0, 1, 3, PT - 1, ST - 1, 1, -1);
        run_op("pause_one_late", 1, 0, 1, PT, 0, 1, -1);
        run_op("busy_one_late", 1, 0, 0, 0, ST, 3, -1);

        // Reset while the streamer is running.
        save_req = 1'b1; slot = 2'd3; core_paused = 1'b1;
        @(posedge clk); #1;
        save_req = 1'b0;
        got_start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (stream_write_start) begin
                got_start = 1'b1;
                break;
            end
        end
        check("rst_run.reached_start", got_start, 1);
        @(posedge clk); #1;
        stream_busy = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_reset_values("rst_run");
        quiet = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (done || error || busy) quiet = 1'b0;
        end
        check("rst_run.no_pulses", quiet, 1);
        @(posedge clk); #1;
        stream_busy = 1'b0; core_paused = 1'b0;
        @(posedge clk); #1;
        run_op("after_reset", 1, 0, 1, 2, 0, 10, -1);

        // Randomized operations.
        for (int n = 0; n < 12; n++) begin
            sv = 1'($urandom_range(1, 0));
            ld = sv ? 1'($urandom_range(1, 0)) : 1'b1;
            run_op($sformatf("rand%0d", n), sv, ld,
                   int'($urandom_range(3, 0)),
                   int'($urandom_range(PT + 3, 0)),
                   int'($urandom_range(ST + 1, 0)),
                   int'($urandom_range(30, 1)),
                   ($urandom_range(1, 0) == 1) ? -2 : -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
